// File: rtl/lock_entry_ctrl.sv
// Keypad-side sequencer for the combination-lock checker: buffers four BCD
// digits, streams them on ENTER and tracks the checker's grant/deny/lock result.
module lock_entry_ctrl #(
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned RESP_TIMEOUT = 16,
    parameter int unsigned GUARD        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       enter_out,
    output logic [3:0] digit_out,
    input  logic       grant_in,
    input  logic       deny_in,
    input  logic       lock_in,
    output logic       granted,
    output logic       denied,
    output logic       locked_out,
    output logic       key_err,
    output logic       resp_err,
    output logic [2:0] digits_entered,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ENTER,
        S_SEND,
        S_WAIT,
        S_GUARD,
        S_LOCKED
    } state_t;

    localparam logic [3:0]  K_CLEAR    = 4'hA;
    localparam logic [3:0]  K_BACK     = 4'hB;
    localparam logic [3:0]  K_ENTER    = 4'hE;
    localparam logic [31:0] IDLE_LAST  = 32'(IDLE_TIMEOUT - 1);
    localparam logic [31:0] RESP_LAST  = 32'(RESP_TIMEOUT - 1);
    localparam logic [31:0] GUARD_LAST = 32'(GUARD - 1);

    state_t      state, state_nxt;
    logic [3:0]  digit_buf [4];
    logic [2:0]  cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [31:0] idle_cnt, idle_nxt;
    logic [31:0] resp_cnt, resp_nxt;
    logic [31:0] guard_cnt, guard_nxt;
    logic        buf_we;
    logic        key_acc;
    logic        granted_nxt, denied_nxt, key_err_nxt, resp_err_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_COLLECT;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case tree leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        idle_nxt     = '0;
        resp_nxt     = '0;
        guard_nxt    = '0;
        buf_we       = 1'b0;
        granted_nxt  = 1'b0;
        denied_nxt   = 1'b0;
        key_err_nxt  = 1'b0;
        resp_err_nxt = 1'b0;
        key_acc      = key_valid && (state == S_COLLECT);

        unique case (state)
            S_COLLECT: begin
                if (key_acc) begin
                    if (key_code <= 4'd9) begin
                        if (cnt < 3'd4) begin
                            buf_we  = 1'b1;
                            cnt_nxt = cnt + 3'd1;
                        end else begin
                            key_err_nxt = 1'b1;
                        end
                    end else if (key_code == K_CLEAR) begin
                        cnt_nxt = '0;
                    end else if (key_code == K_BACK) begin
                        if (cnt != '0) cnt_nxt = cnt - 3'd1;
                    end else if (key_code == K_ENTER) begin
                        if (cnt == 3'd4) begin
                            state_nxt = S_ENTER;
                        end else begin
                            key_err_nxt = 1'b1;
                            cnt_nxt     = '0;
                        end
                    end else begin
                        key_err_nxt = 1'b1;
                    end
                end else if (cnt != '0) begin
                    // Abandoned partial entries are silently discarded.
                    if (idle_cnt >= IDLE_LAST) cnt_nxt  = '0;
                    else                       idle_nxt = idle_cnt + 32'd1;
                end
            end

            S_ENTER: begin
                state_nxt = S_SEND;
                idx_nxt   = '0;
            end

            S_SEND, S_WAIT: begin
                if (deny_in) begin
                    denied_nxt  = 1'b1;
                    key_err_nxt = grant_in;
                    cnt_nxt     = '0;
                    state_nxt   = S_GUARD;
                end else if (grant_in) begin
                    granted_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = S_COLLECT;
                end else if (state == S_SEND) begin
                    if (idx == 2'd3) state_nxt = S_WAIT;
                    else             idx_nxt   = idx + 2'd1;
                end else if (resp_cnt >= RESP_LAST) begin
                    resp_err_nxt = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = S_COLLECT;
                end else begin
                    resp_nxt = resp_cnt + 32'd1;
                end
            end

            S_GUARD: begin
                if (guard_cnt >= GUARD_LAST) state_nxt = S_COLLECT;
                else                         guard_nxt = guard_cnt + 32'd1;
            end

            S_LOCKED: begin
                if (!lock_in) begin
                    state_nxt = S_COLLECT;
                    cnt_nxt   = '0;
                end
            end

            default: state_nxt = S_COLLECT;
        endcase

        // A checker lockout overrides whatever the current state decided.
        if (lock_in && state != S_LOCKED) begin
            state_nxt    = S_LOCKED;
            cnt_nxt      = '0;
            buf_we       = 1'b0;
            granted_nxt  = 1'b0;
            denied_nxt   = 1'b0;
            key_err_nxt  = 1'b0;
            resp_err_nxt = 1'b0;
        end
    end

    // NOTE: the digit buffer is small and explicitly reset so a stale code
    // never survives a reset; larger storage would normally stay unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) digit_buf[i] <= '0;
            cnt       <= '0;
            idx       <= '0;
            idle_cnt  <= '0;
            resp_cnt  <= '0;
            guard_cnt <= '0;
            granted   <= 1'b0;
            denied    <= 1'b0;
            key_err   <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            if (buf_we) digit_buf[cnt[1:0]] <= key_code;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            idle_cnt  <= idle_nxt;
            resp_cnt  <= resp_nxt;
            guard_cnt <= guard_nxt;
            granted   <= granted_nxt;
            denied    <= denied_nxt;
            key_err   <= key_err_nxt;
            resp_err  <= resp_err_nxt;
        end
    end

    // A deny seen mid-stream silences the digit bus in the same cycle.
    always_comb begin
        key_ready      = (state == S_COLLECT);
        enter_out      = (state == S_ENTER);
        locked_out     = (state == S_LOCKED);
        busy           = (state != S_COLLECT);
        digits_entered = cnt;
        digit_out      = (state == S_SEND && !deny_in) ? digit_buf[idx] : 4'd0;
    end

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Scoreboard bench for lock_entry_ctrl: stimulus queues expected events, a
// monitor pops and compares every strobe, digit and pulse the DUT presents.
module tb_lock_entry_ctrl;

    localparam int IDLE_TIMEOUT = 1000;
    localparam int RESP_TIMEOUT = 16;
    localparam int GUARD        = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       grant_in = 1'b0;
    logic       deny_in = 1'b0;
    logic       lock_in = 1'b0;
    logic       key_ready, enter_out, granted, denied, locked_out;
    logic       key_err, resp_err, busy;
    logic [3:0] digit_out;
    logic [2:0] digits_entered;

    lock_entry_ctrl #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .RESP_TIMEOUT(RESP_TIMEOUT),
        .GUARD       (GUARD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .enter_out     (enter_out),
        .digit_out     (digit_out),
        .grant_in      (grant_in),
        .deny_in       (deny_in),
        .lock_in       (lock_in),
        .granted       (granted),
        .denied        (denied),
        .locked_out    (locked_out),
        .key_err       (key_err),
        .resp_err      (resp_err),
        .digits_entered(digits_entered),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_ENTER, EV_DIGIT, EV_GRANT, EV_DENY, EV_KERR, EV_RERR} ev_kind_t;
    typedef struct {
        int       cyc;
        ev_kind_t kind;
        int       val;
    } ev_t;

    ev_t sb[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] pack(input ev_kind_t k, input int v, input int c);
        return {8'(k), 8'(v), 16'(c)};
    endfunction

    task automatic expect_ev(input int c, input ev_kind_t k, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        sb.push_back(e);
    endtask

    task automatic report_missing(input ev_t e);
        n_total++;
        $display("FAIL missing_event: kind %0d value %0h due at cycle %0d never seen",
                 int'(e.kind), e.val, e.cyc);
    endtask

    task automatic observe(input ev_kind_t k, input int v);
        ev_t e;
        if (sb.size() == 0 || sb[0].cyc > cyc) begin
            check("unexpected_event", pack(k, v, cyc), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check("event(kind,val,cycle)", pack(k, v, cyc), pack(e.kind, e.val, e.cyc));
        end
    endtask

    // Monitor: samples one time unit after the falling edge, once inputs have settled.
    initial forever begin
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc < cyc) report_missing(sb.pop_front());
        if (enter_out)       observe(EV_ENTER, 0);
        if (digit_out != '0) observe(EV_DIGIT, int'(digit_out));
        if (granted)         observe(EV_GRANT, 0);
        if (denied)          observe(EV_DENY, 0);
        if (key_err)         observe(EV_KERR, 0);
        if (resp_err)        observe(EV_RERR, 0);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code, input bit err);
        if (err) expect_ev(cyc + 1, EV_KERR, 0);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Types four digits then ENTER; t is the enter-strobe cycle, nstream the
    // number of digits expected on the bus before any abort.
    task automatic enter_code(input logic [15:0] code, input int nstream, output int t);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = code[15-4*i -: 4];
            press(d, 1'b0);
            check("digits_entered_typing", 32'(digits_entered), 32'(i + 1));
        end
        t = cyc + 1;
        expect_ev(t, EV_ENTER, 0);
        for (int k = 0; k < nstream; k++) begin
            d = code[15-4*k -: 4];
            expect_ev(t + 1 + k, EV_DIGIT, int'(d));
        end
        press(4'hE, 1'b0);
    endtask

    task automatic deny_attempt(input logic [15:0] code, output int t);
        enter_code(code, 2, t);
        wait_until(t + 3);
        expect_ev(t + 4, EV_DENY, 0);
        deny_in = 1'b1;
        @(negedge clk);
        deny_in = 1'b0;
        check("guard_key_ready_first", 32'(key_ready), 32'd0);
    endtask

    int t;
    int a;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digit_out", 32'(digit_out), 32'd0);
        check("rst_digits_entered", 32'(digits_entered), 32'd0);
        check("rst_locked_out", 32'(locked_out), 32'd0);
        check("rst_pulses", {granted, denied, key_err, resp_err, enter_out}, 5'd0);

        // Editing keys, early ENTER, invalid code, fifth digit, clear.
        press(4'h1, 1'b0); check("bs_seq_1", 32'(digits_entered), 32'd1);
        press(4'h5, 1'b0); check("bs_seq_2", 32'(digits_entered), 32'd2);
        press(4'hB, 1'b0); check("bs_seq_3", 32'(digits_entered), 32'd1);
        press(4'hB, 1'b0); check("bs_seq_4", 32'(digits_entered), 32'd0);
        press(4'hB, 1'b0); check("bs_at_zero", 32'(digits_entered), 32'd0);
        press(4'hE, 1'b1); check("early_enter", 32'(digits_entered), 32'd0);
        press(4'hC, 1'b1); check("invalid_code", 32'(digits_entered), 32'd0);
        for (int i = 1; i <= 4; i++) press(4'(i), 1'b0);
        press(4'h6, 1'b1); check("fifth_digit", 32'(digits_entered), 32'd4);
        press(4'hA, 1'b0); check("clear_key", 32'(digits_entered), 32'd0);

        // Granted attempt.
        enter_code(16'h1537, 4, t);
        expect_ev(t + 7, EV_GRANT, 0);
        wait_until(t + 6);
        grant_in = 1'b1;
        @(negedge clk);
        grant_in = 1'b0;
        check("grant_digits_cleared", 32'(digits_entered), 32'd0);
        check("grant_key_ready", 32'(key_ready), 32'd1);

        // First deny, aborted mid-stream, then the guard window.
        deny_attempt(16'h2537, t);
        wait_until(t + 3 + GUARD);
        check("guard_key_ready_last", 32'(key_ready), 32'd0);
        wait_until(t + 4 + GUARD);
        check("guard_reopen", 32'(key_ready), 32'd1);

        // Second deny: grant and deny together count as deny plus key_err.
        enter_code(16'h9191, 4, t);
        expect_ev(t + 7, EV_DENY, 0);
        expect_ev(t + 7, EV_KERR, 0);
        wait_until(t + 6);
        grant_in = 1'b1;
        deny_in  = 1'b1;
        @(negedge clk);
        grant_in = 1'b0;
        deny_in  = 1'b0;
        wait_until(t + 6 + GUARD);
        check("both_guard_closed", 32'(key_ready), 32'd0);
        wait_until(t + 7 + GUARD);
        check("both_guard_reopen", 32'(key_ready), 32'd1);

        // Third deny followed by a lockout.
        deny_attempt(16'h2537, t);
        wait_until(t + 5);
        lock_in = 1'b1;
        @(negedge clk);
        check("locked_out_set", 32'(locked_out), 32'd1);
        check("locked_key_ready", 32'(key_ready), 32'd0);
        press(4'h4, 1'b0);
        check("locked_key_ignored", 32'(digits_entered), 32'd0);
        lock_in = 1'b0;
        @(negedge clk);
        check("unlock_locked_out", 32'(locked_out), 32'd0);
        check("unlock_key_ready", 32'(key_ready), 32'd1);

        // No checker response.
        enter_code(16'h4826, 4, t);
        expect_ev(t + 5 + RESP_TIMEOUT, EV_RERR, 0);
        wait_until(t + 4 + RESP_TIMEOUT);
        check("resp_wait_count", 32'(digits_entered), 32'd4);
        wait_until(t + 5 + RESP_TIMEOUT);
        check("resp_timeout_count", 32'(digits_entered), 32'd0);
        check("resp_timeout_ready", 32'(key_ready), 32'd1);

        // Idle auto-clear.
        press(4'h9, 1'b0);
        a = cyc;
        check("idle_start", 32'(digits_entered), 32'd1);
        wait_until(a + IDLE_TIMEOUT - 1);
        check("idle_before_expiry", 32'(digits_entered), 32'd1);
        wait_until(a + IDLE_TIMEOUT);
        check("idle_expired", 32'(digits_entered), 32'd0);

        // Reset in the middle of the digit stream.
        enter_code(16'h1234, 2, t);
        wait_until(t + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_digit_out", 32'(digit_out), 32'd0);
        check("mid_rst_key_ready", 32'(key_ready), 32'd1);
        check("mid_rst_digits", 32'(digits_entered), 32'd0);
        check("mid_rst_levels", {busy, locked_out, enter_out, granted, denied, key_err, resp_err}, 7'd0);

        repeat (4) @(negedge clk);
        #2;
        while (sb.size() > 0) report_missing(sb.pop_front());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lock_entry_ctrl.md
Name: lock_entry_ctrl

Overview:
Keypad-side sequencer for the combination-lock checker. It collects BCD digits from a keypad handshake into a 4-digit buffer and, on the ENTER key, issues a one-cycle enter strobe followed by the four digits on consecutive cycles, matching the checker's one-digit-per-cycle CHECK states. It then tracks the checker's grant/deny/lock outputs, gates the keypad during lockout, and flags protocol faults.

Parameters:
IDLE_TIMEOUT, 1000, cycles without an accepted key (buffer non-empty) before the buffer is auto-cleared
RESP_TIMEOUT, 16, cycles allowed in S_WAIT for a checker result
GUARD, 3, cycles after deny_in spent watching for lock_in before the keypad reopens

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_valid  in  1  keypad code valid
key_code  in  4  0-9 digit, 4'hA clear, 4'hB backspace, 4'hE enter; 4'hC/4'hD/4'hF invalid
key_ready  out  1  keypad code accepted when key_valid && key_ready
enter_out  out  1  enter strobe to checker
digit_out  out  4  digit to checker (ip_pass)
grant_in  in  1  checker grant
deny_in  in  1  checker deny
lock_in  in  1  checker lock
granted  out  1  1-cycle pulse, access granted
denied  out  1  1-cycle pulse, attempt denied
locked_out  out  1  level, lockout active
key_err  out  1  1-cycle pulse, invalid/illegal key
resp_err  out  1  1-cycle pulse, checker response timeout
digits_entered  out  3  buffered digit count, 0-4
busy  out  1  high in every state except S_COLLECT

Behaviour:
- Reset (synchronous): state S_COLLECT; buffer and counters cleared; key_ready=1; all other outputs 0, digit_out=0.
- S_COLLECT (key_ready=1), on an accepted key:
  - digit with count<4: append, count+1.
  - digit with count=4: key_err, ignored.
  - clear: count=0.
  - backspace: count-1; no effect at 0.
  - enter with count=4: go to S_ENTER.
  - enter with count<4: key_err, count=0.
  - invalid code: key_err only.
- Idle timer counts while count>0 and no key is accepted; reloads on each accepted key. At IDLE_TIMEOUT, count=0 with no error pulse.
- lock_in=1 in any state except S_LOCKED: go to S_LOCKED (takes priority over any key in that cycle).
- S_ENTER: one cycle. key_ready=0, enter_out=1. Next state S_SEND.
- S_SEND: four cycles, idx 0..3. digit_out = buffer[idx], first-entered digit first, so digit k is driven on cycle T+k (T = enter cycle). After idx 3, go to S_WAIT. digit_out=0 outside S_SEND.
- Results are sampled in S_SEND and S_WAIT:
  - grant_in: granted pulse next cycle; count=0; return to S_COLLECT.
  - deny_in: streaming aborts; denied pulse next cycle; count=0; go to S_GUARD.
  - grant_in and deny_in together: treat as deny and pulse key_err.
- S_WAIT: RESP_TIMEOUT expiry with no result gives resp_err, count=0, return to S_COLLECT.
- S_GUARD: GUARD cycles, key_ready=0. lock_in gives S_LOCKED; otherwise return to S_COLLECT.
- S_LOCKED: locked_out=1, key_ready=0, keypad codes ignored (no key_err). lock_in=0 gives locked_out=0 next cycle and S_COLLECT with an empty buffer.
- Output timing: pulse outputs are registered, exactly one cycle wide, and may not overlap except key_err with denied.
- Counters: saturate and never wrap. Idle and response timers are 32-bit.

Test Plan:
- Keys 1,5,3,7,E; grant_in at T+6 -> enter_out at T; digit_out 1,5,3,7 on T+1..T+4; granted at T+7; digits_entered=0; key_ready=1 at T+7.
- Keys 2,5,3,7,E; deny_in at T+3 -> digit_out stops after T+2; denied at T+4; key_ready=0 for GUARD cycles, then 1.
- Three denies, lock_in rises 2 cycles after the third deny_in -> locked_out=1, keys ignored; lock_in falls -> locked_out=0 and key_ready=1 next cycle.
- Keys 1,5,B,B,B,E -> digits_entered 1,2,1,0,0; key_err on E; code 4'hC -> key_err; 5th digit -> key_err and count stays 4.
- Full entry with no checker response -> resp_err exactly RESP_TIMEOUT cycles after entering S_WAIT; count=0.
- Key 9, then IDLE_TIMEOUT idle cycles -> digits_entered=0, no pulses. rst asserted during S_SEND -> next cycle all outputs at reset values and digit_out=0.
